mem_arbiter: RTL and testbench

- Sits between the requesters (instruction fetch, LSB load, LSB store) and the byte-serial memory controller, and shares that single channel between them.
- Latches one request at a time, drives the controller's command inputs, and waits for its done pulse. It then returns the result to the winning requester with a one-cycle ack.
- Honours pipeline flush (clear): aborts speculative traffic (fetch, load) but never a store already granted.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - owner, state and length encodings shared by the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Number of low-order bytes a load of the given length keeps.
  // Unsupported lengths keep as many bytes as they name.
  function automatic int len_bytes(input logic [2:0] len);
    case (len)
      LEN_B:   len_bytes = 1;
      LEN_H:   len_bytes = 2;
      LEN_W:   len_bytes = 4;
      default: len_bytes = int'(len);
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational store > load > fetch picker with fetch override
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       ld_req,
  input  logic       st_req,
  input  logic       hold_spec,
  input  logic       fair_fetch,
  output logic [1:0] owner
);

  // Stores are never speculative, so a flush only masks fetch and load.
  always_comb begin
    owner = OWN_NONE;
    if (fair_fetch && if_req && !hold_spec) begin
      owner = OWN_IF;
    end else if (st_req) begin
      owner = OWN_ST;
    end else if (ld_req && !hold_spec) begin
      owner = OWN_LD;
    end else if (if_req && !hold_spec) begin
      owner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the byte-serial memory controller between fetch, load and store; MEM_ARB_FAIRNESS_EN adds fetch anti-starvation
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_data,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,
  output logic              mc_valid,
  output logic              mc_we,
  output logic              mc_inst,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_len,
  output logic [DATA_W-1:0] mc_wdata,
  output logic              mc_abort,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  localparam int NBYTES = DATA_W / 8;

  state_t            state, state_d;
  owner_t            owner, owner_d;
  logic [1:0]        pick_raw;
  owner_t            pick;
  logic              fair_fetch;

  logic              mc_valid_d, mc_we_d, mc_inst_d, mc_abort_d;
  logic [ADDR_W-1:0] mc_addr_d;
  logic [2:0]        mc_len_d;
  logic [DATA_W-1:0] mc_wdata_d;
  logic              if_ack_r, ld_ack_r;
  logic              if_ack_d, ld_ack_d, st_ack_d;
  logic [DATA_W-1:0] if_data_d, ld_data_d;
  logic [DATA_W-1:0] ld_mask;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .ld_req     (ld_req),
    .st_req     (st_req),
    .hold_spec  (clear),
    .fair_fetch (fair_fetch),
    .owner      (pick_raw)
  );

  assign pick = owner_t'(pick_raw);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign fair_fetch = (starve_cnt == CNT_W'(STARVE_MAX));

  // Count data grants that overtook a waiting fetch; any fetch grant or an idle fetch port resets it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (rdy_in && state == ST_IDLE && pick != OWN_NONE) begin
      if (pick == OWN_IF || !if_req) begin
        starve_cnt <= '0;
      end else if (!fair_fetch) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  // Pure fixed priority: the fetch override never fires.
  assign fair_fetch = (STARVE_MAX < 0);
`endif

  // Keep only the bytes the load asked for; the command length is stable while busy.
  always_comb begin
    ld_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < len_bytes(mc_len)) begin
        ld_mask[i*8 +: 8] = 8'hFF;
      end
    end
  end

  // Next-state and next-output logic for the single shared channel.
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    mc_valid_d = mc_valid;
    mc_we_d    = mc_we;
    mc_inst_d  = mc_inst;
    mc_addr_d  = mc_addr;
    mc_len_d   = mc_len;
    mc_wdata_d = mc_wdata;
    mc_abort_d = 1'b0;
    if_ack_d   = 1'b0;
    ld_ack_d   = 1'b0;
    st_ack_d   = 1'b0;
    if_data_d  = if_data;
    ld_data_d  = ld_data;
    case (state)
      ST_IDLE: begin
        if (pick != OWN_NONE) begin
          state_d    = ST_BUSY;
          owner_d    = pick;
          mc_valid_d = 1'b1;
          mc_wdata_d = '0;
          case (pick)
            OWN_ST: begin
              mc_we_d    = 1'b1;
              mc_inst_d  = 1'b0;
              mc_addr_d  = st_addr;
              mc_len_d   = st_len;
              mc_wdata_d = st_data;
            end
            OWN_LD: begin
              mc_we_d   = 1'b0;
              mc_inst_d = 1'b0;
              mc_addr_d = ld_addr;
              mc_len_d  = ld_len;
            end
            default: begin
              mc_we_d   = 1'b0;
              mc_inst_d = 1'b1;
              mc_addr_d = if_addr;
              mc_len_d  = LEN_W;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (clear && owner != OWN_ST) begin
          state_d    = ST_IDLE;
          owner_d    = OWN_NONE;
          mc_valid_d = 1'b0;
          mc_abort_d = 1'b1;
        end else if (mc_done) begin
          state_d    = ST_RESP;
          mc_valid_d = 1'b0;
          case (owner)
            OWN_IF: begin
              if_data_d = mc_rdata;
              if_ack_d  = 1'b1;
            end
            OWN_LD: begin
              ld_data_d = mc_rdata & ld_mask;
              ld_ack_d  = 1'b1;
            end
            OWN_ST: st_ack_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      mc_valid <= 1'b0;
      mc_we    <= 1'b0;
      mc_inst  <= 1'b0;
      mc_addr  <= '0;
      mc_len   <= '0;
      mc_wdata <= '0;
      mc_abort <= 1'b0;
      if_ack_r <= 1'b0;
      ld_ack_r <= 1'b0;
      st_ack   <= 1'b0;
      if_data  <= '0;
      ld_data  <= '0;
    end else if (rdy_in) begin
      state    <= state_d;
      owner    <= owner_d;
      mc_valid <= mc_valid_d;
      mc_we    <= mc_we_d;
      mc_inst  <= mc_inst_d;
      mc_addr  <= mc_addr_d;
      mc_len   <= mc_len_d;
      mc_wdata <= mc_wdata_d;
      mc_abort <= mc_abort_d;
      if_ack_r <= if_ack_d;
      ld_ack_r <= ld_ack_d;
      st_ack   <= st_ack_d;
      if_data  <= if_data_d;
      ld_data  <= ld_data_d;
    end
  end

  // A flush arriving during the response cycle withdraws speculative acks.
  assign if_ack = if_ack_r & ~(clear & rdy_in);
  assign ld_ack = ld_ack_r & ~(clear & rdy_in);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        if_req, ld_req, st_req, mc_done;
  logic [31:0] if_addr, ld_addr, st_addr, st_data, mc_rdata;
  logic [2:0]  ld_len, st_len;
  logic        if_ack, ld_ack, st_ack;
  logic [31:0] if_data, ld_data;
  logic        mc_valid, mc_we, mc_inst, mc_abort;
  logic [31:0] mc_addr, mc_wdata;
  logic [2:0]  mc_len;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] addr;
    logic [2:0]  len;
    logic        we;
    logic        inst;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_ack(ld_ack), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_ack(st_ack),
    .mc_valid(mc_valid), .mc_we(mc_we), .mc_inst(mc_inst), .mc_addr(mc_addr),
    .mc_len(mc_len), .mc_wdata(mc_wdata), .mc_abort(mc_abort),
    .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle_inputs();
    rdy_in = 1'b1; clear = 1'b0; mc_done = 1'b0; mc_rdata = '0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0;
    ld_len = LEN_W; st_len = LEN_W;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic push_txn(input logic [1:0] who, input logic [31:0] addr, input logic [2:0] len,
                          input logic we, input logic inst, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [31:0] data);
    txn_t t;
    t.who = who; t.addr = addr; t.len = len; t.we = we; t.inst = inst;
    t.wdata = wdata; t.rdata = rdata; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mc_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  // Grant the next expected transaction on the channel and check command, ack and data.
  task automatic serve_next(input int delay, output logic [1:0] who);
    txn_t       t;
    bit         ok;
    logic [2:0] ea;
    who = OWN_NONE;
    wait_valid(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++;
      $display("FAIL serve_grant: mc_valid=%b pending=%0d required valid with pending txn", mc_valid, exp_q.size());
      return;
    end
    t = exp_q.pop_front();
    who = t.who;
    checks++;
    if ({mc_we, mc_inst, mc_addr, mc_len} !== {t.we, t.inst, t.addr, t.len} || (t.we && mc_wdata !== t.wdata)) begin
      errors++;
      $display("FAIL serve_cmd: we=%b inst=%b addr=%h len=%0d wdata=%h required we=%b inst=%b addr=%h len=%0d wdata=%h",
               mc_we, mc_inst, mc_addr, mc_len, mc_wdata, t.we, t.inst, t.addr, t.len, t.wdata);
    end
    repeat (delay) @(negedge clk_in);
    mc_done = 1'b1; mc_rdata = t.rdata;
    @(negedge clk_in);
    mc_done = 1'b0; mc_rdata = '0;
    ea = (t.who == OWN_ST) ? 3'b100 : (t.who == OWN_LD) ? 3'b010 : 3'b001;
    checks++;
    if ({st_ack, ld_ack, if_ack} !== ea || mc_valid !== 1'b0) begin
      errors++;
      $display("FAIL serve_ack: acks(st,ld,if)=%b valid=%b required %b valid=0", {st_ack, ld_ack, if_ack}, mc_valid, ea);
    end
    if (t.who != OWN_ST) begin
      checks++;
      if ((t.who == OWN_IF ? if_data : ld_data) !== t.data) begin
        errors++;
        $display("FAIL serve_data: got %h required %h", (t.who == OWN_IF ? if_data : ld_data), t.data);
      end
    end
    @(negedge clk_in);
    checks++;
    if ({st_ack, ld_ack, if_ack} !== 3'b000) begin
      errors++;
      $display("FAIL ack_width: acks=%b required 000", {st_ack, ld_ack, if_ack});
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b0;
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({if_ack, ld_ack, st_ack, mc_valid, mc_we, mc_inst, mc_abort} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000000", {if_ack, ld_ack, st_ack, mc_valid, mc_we, mc_inst, mc_abort});
    end
    checks++;
    if ({if_data, ld_data, mc_addr, mc_wdata, mc_len} !== '0) begin
      errors++;
      $display("FAIL reset_buses: if_data=%h ld_data=%h addr=%h wdata=%h len=%0d required 0", if_data, ld_data, mc_addr, mc_wdata, mc_len);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    mc_done = 1'b1; mc_rdata = 32'hFFFF_FFFF;
    @(negedge clk_in);
    mc_done = 1'b0; mc_rdata = '0;
    checks++;
    if ({if_ack, ld_ack, st_ack, mc_valid} !== 4'b0 || if_data !== '0 || ld_data !== '0) begin
      errors++;
      $display("FAIL done_in_idle: acks=%b valid=%b if_data=%h ld_data=%h required all 0", {if_ack, ld_ack, st_ack}, mc_valid, if_data, ld_data);
    end
  endtask

  task automatic test_fetch();
    txn_t t;
    bit   stable;
    do_reset();
    push_txn(OWN_IF, 32'h0000_1000, LEN_W, 1'b0, 1'b1, '0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    if_req = 1'b1; if_addr = 32'h0000_1000;
    @(negedge clk_in);
    t = exp_q.pop_front();
    checks++;
    if (mc_valid !== 1'b1) begin
      errors++;
      $display("FAIL fetch_latency: mc_valid=%b required 1 one cycle after request", mc_valid);
    end
    checks++;
    if ({mc_we, mc_inst, mc_addr, mc_len} !== {t.we, t.inst, t.addr, t.len}) begin
      errors++;
      $display("FAIL fetch_cmd: we=%b inst=%b addr=%h len=%0d required we=%b inst=%b addr=%h len=%0d",
               mc_we, mc_inst, mc_addr, mc_len, t.we, t.inst, t.addr, t.len);
    end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      if (mc_valid !== 1'b1 || mc_addr !== t.addr || if_ack !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL fetch_hold: valid=%b addr=%h ack=%b required 1/%h/0", mc_valid, mc_addr, if_ack, t.addr);
    end
    mc_done = 1'b1; mc_rdata = t.rdata;
    @(negedge clk_in);
    mc_done = 1'b0; mc_rdata = '0;
    checks++;
    if (if_ack !== 1'b1 || if_data !== t.data || mc_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack: ack=%b data=%h valid=%b required 1/%h/0", if_ack, if_data, mc_valid, t.data);
    end
    if_req = 1'b0;
    @(negedge clk_in);
    checks++;
    if (if_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack_width: ack=%b required 0", if_ack);
    end
  endtask

  task automatic test_contention();
    logic [1:0] who;
    do_reset();
    push_txn(OWN_ST, 32'h0000_4000, LEN_W, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0);
    push_txn(OWN_LD, 32'h0000_5000, LEN_H, 1'b0, 1'b0, '0, 32'h1234_ABCD, 32'h0000_ABCD);
    push_txn(OWN_IF, 32'h0000_6000, LEN_W, 1'b0, 1'b1, '0, 32'h0BAD_C0DE, 32'h0BAD_C0DE);
    st_req = 1'b1; st_addr = 32'h0000_4000; st_len = LEN_W; st_data = 32'hCAFE_F00D;
    ld_req = 1'b1; ld_addr = 32'h0000_5000; ld_len = LEN_H;
    if_req = 1'b1; if_addr = 32'h0000_6000;
    for (int k = 0; k < 3; k++) begin
      serve_next(2 + k, who);
      if (who == OWN_ST) st_req = 1'b0;
      else if (who == OWN_LD) ld_req = 1'b0;
      else if_req = 1'b0;
    end
  endtask

  task automatic test_byte_load();
    logic [1:0] who;
    do_reset();
    push_txn(OWN_LD, 32'h0000_0103, LEN_B, 1'b0, 1'b0, '0, 32'hFFFF_FF80, 32'h0000_0080);
    ld_req = 1'b1; ld_addr = 32'h0000_0103; ld_len = LEN_B;
    serve_next(3, who);
    ld_req = 1'b0;
  endtask

  task automatic test_flush_load();
    bit quiet;
    do_reset();
    ld_req = 1'b1; ld_addr = 32'h0000_7000; ld_len = LEN_W;
    @(negedge clk_in);
    @(negedge clk_in);
    clear = 1'b1; mc_done = 1'b1; mc_rdata = 32'h5555_5555;
    @(negedge clk_in);
    checks++;
    if (mc_valid !== 1'b0 || mc_abort !== 1'b1 || ld_ack !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: valid=%b abort=%b ack=%b required 0/1/0", mc_valid, mc_abort, ld_ack);
    end
    clear = 1'b0; mc_done = 1'b0; mc_rdata = '0; ld_req = 1'b0;
    @(negedge clk_in);
    checks++;
    if (mc_abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_width: abort=%b required 0", mc_abort);
    end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (ld_ack !== 1'b0 || mc_valid !== 1'b0 || ld_data !== '0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL flush_quiet: ack=%b valid=%b ld_data=%h required 0/0/0", ld_ack, mc_valid, ld_data);
    end
    clear = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0A00;
    @(negedge clk_in);
    checks++;
    if (mc_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks_fetch: valid=%b required 0", mc_valid);
    end
    clear = 1'b0;
    @(negedge clk_in);
    checks++;
    if (mc_valid !== 1'b1 || mc_inst !== 1'b1 || mc_addr !== 32'h0000_0A00) begin
      errors++;
      $display("FAIL idle_after_flush: valid=%b inst=%b addr=%h required 1/1/00000a00", mc_valid, mc_inst, mc_addr);
    end
    mc_done = 1'b1; mc_rdata = 32'h7777_0000;
    @(negedge clk_in);
    mc_done = 1'b0; mc_rdata = '0;
    clear = 1'b1;
    #1;
    checks++;
    if (if_ack !== 1'b0) begin
      errors++;
      $display("FAIL resp_flush: if_ack=%b required 0", if_ack);
    end
    @(negedge clk_in);
    clear = 1'b0; if_req = 1'b0;
    checks++;
    if (if_ack !== 1'b0 || mc_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_flush_after: ack=%b valid=%b required 0/0", if_ack, mc_valid);
    end
  endtask

  task automatic test_flush_store();
    bit held;
    do_reset();
    clear = 1'b1;
    st_req = 1'b1; st_addr = 32'h0000_8000; st_len = LEN_B; st_data = 32'h0000_00A5;
    @(negedge clk_in);
    checks++;
    if (mc_valid !== 1'b1 || mc_we !== 1'b1 || mc_wdata !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL store_under_clear: valid=%b we=%b wdata=%h required 1/1/000000a5", mc_valid, mc_we, mc_wdata);
    end
    held = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (mc_valid !== 1'b1 || mc_abort !== 1'b0) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL store_not_aborted: valid=%b abort=%b required 1/0", mc_valid, mc_abort);
    end
    mc_done = 1'b1;
    @(negedge clk_in);
    mc_done = 1'b0;
    checks++;
    if (st_ack !== 1'b1) begin
      errors++;
      $display("FAIL store_ack: st_ack=%b required 1", st_ack);
    end
    st_req = 1'b0; clear = 1'b0;
    @(negedge clk_in);
    checks++;
    if (st_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_ack_width: st_ack=%b required 0", st_ack);
    end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_9000;
    @(negedge clk_in);
    rdy_in = 1'b0; mc_done = 1'b1; mc_rdata = 32'h1111_1111;
    @(negedge clk_in);
    mc_done = 1'b0; mc_rdata = '0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (mc_valid !== 1'b1 || if_ack !== 1'b0 || if_data !== '0) begin
      errors++;
      $display("FAIL rdy_freeze: valid=%b ack=%b data=%h required 1/0/0", mc_valid, if_ack, if_data);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (mc_valid !== 1'b1 || if_ack !== 1'b0) begin
      errors++;
      $display("FAIL rdy_done_ignored: valid=%b ack=%b required 1/0", mc_valid, if_ack);
    end
    mc_done = 1'b1; mc_rdata = 32'h2222_2222;
    @(negedge clk_in);
    mc_done = 1'b0; mc_rdata = '0;
    checks++;
    if (if_ack !== 1'b1 || if_data !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rdy_resume: ack=%b data=%h required 1/22222222", if_ack, if_data);
    end
    if_req = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_fairness();
    logic [1:0] who;
    int         nload;
    int         fetch_slot;
    do_reset();
`ifdef MEM_ARB_FAIRNESS_EN
    fetch_slot = 4;
`else
    fetch_slot = 5;
`endif
    nload = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == fetch_slot) begin
        push_txn(OWN_IF, 32'h0000_2000, LEN_W, 1'b0, 1'b1, '0, 32'hF00D_0000, 32'hF00D_0000);
      end else begin
        push_txn(OWN_LD, 32'h0000_3000 + 32'(4 * nload), LEN_W, 1'b0, 1'b0, '0,
                 32'hA000_0000 + 32'(nload), 32'hA000_0000 + 32'(nload));
        nload++;
      end
    end
    nload = 0;
    if_req = 1'b1; if_addr = 32'h0000_2000;
    ld_req = 1'b1; ld_addr = 32'h0000_3000; ld_len = LEN_W;
    for (int k = 0; k < 6; k++) begin
      serve_next(1, who);
      if (who == OWN_LD) begin
        nload++;
        if (nload == 5) ld_req = 1'b0;
        else ld_addr = 32'h0000_3000 + 32'(4 * nload);
      end else begin
        if_req = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fair_drain: pending=%0d required 0", exp_q.size());
    end
    if_req = 1'b0; ld_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_byte_load();
    test_flush_load();
    test_flush_store();
    test_rdy_freeze();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
